// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment codes are active-low: bit0..6 = a..g, bit7 = dp.
package seg7_pkg;

  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  localparam logic [7:0] DIG_OFF  = 8'hFF;

  localparam logic [3:0]  SEP_NIB       = 4'ha;
  localparam logic [31:0] DISP_RST_WORD = 32'h00a00a00;

  // Everything that is frozen for the duration of one scan frame.
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  blink;
    logic [7:0]  dp;
  } snap_t;

  localparam snap_t SNAP_RST = '{data: DISP_RST_WORD, blink: 8'h00, dp: 8'h00};

  // Nibble shown on digit idx (digit 7 is the leftmost, bits [31:28]).
  function automatic logic [3:0] nib_sel(input logic [31:0] word, input logic [2:0] idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg7_scan_disp_if.sv
// Display-side signal bundle: time word and masks in, segment/digit drives out.
interface seg7_scan_disp_if;
  // Level signals, no valid/ready handshake: the driver samples disp_data and the
  // masks only on the frame-boundary cycle, and disp_en on every cycle.
  logic [31:0] disp_data;
  logic [7:0]  blink_mask;
  logic [7:0]  dp_mask;
  logic        disp_en;
  logic [7:0]  seg;
  logic [7:0]  dig_sel;

  modport master (
    output disp_data,
    output blink_mask,
    output dp_mask,
    output disp_en,
    input  seg,
    input  dig_sel
  );

  modport slave (
    input  disp_data,
    input  blink_mask,
    input  dp_mask,
    input  disp_en,
    output seg,
    output dig_sel
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low a..g decode. Codes above the separator
// nibble render blank and flag o_blank so the caller can also suppress dp.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg,
  output logic       o_blank
);

  always_comb begin
    o_seg   = SEG_OFF[6:0];
    o_blank = 1'b0;
    case (i_nib)
      4'h0:    o_seg = SEG_0[6:0];
      4'h1:    o_seg = SEG_1[6:0];
      4'h2:    o_seg = SEG_2[6:0];
      4'h3:    o_seg = SEG_3[6:0];
      4'h4:    o_seg = SEG_4[6:0];
      4'h5:    o_seg = SEG_5[6:0];
      4'h6:    o_seg = SEG_6[6:0];
      4'h7:    o_seg = SEG_7[6:0];
      4'h8:    o_seg = SEG_8[6:0];
      4'h9:    o_seg = SEG_9[6:0];
      SEP_NIB: o_seg = SEG_DASH[6:0];
      default: begin
        o_seg   = SEG_OFF[6:0];
        o_blank = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_disp.sv
// 8-digit multiplexed scan driver rendering the packed HH-MM-SS word on a
// common-anode display, with per-digit blink and decimal-point masks.
module seg7_scan_disp
  import seg7_pkg::*;
#(
  parameter int SCAN_CNT  = 50000,
  parameter int BLANK_CYC = 100,
  parameter int BLINK_CNT = 25000000
) (
  input  logic          sys_clk,
  input  logic          rst,
  seg7_scan_disp_if.slave disp
);

  localparam int SW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam int BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CNT - 1);
  localparam logic [SW-1:0] BLANK_TH   = SW'(BLANK_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CNT - 1);

  logic [SW-1:0] r_scan_cnt;
  logic [2:0]    r_idx;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  snap_t         r_snap;
  logic [7:0]    r_seg;
  logic [7:0]    r_dig_sel;

  logic          w_scan_wrap;
  logic          w_frame_end;
  logic          w_blink_wrap;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg7;
  logic          w_blank;
  logic          w_blink_off;
  logic [7:0]    w_seg_nxt;
  logic [7:0]    w_dig_nxt;

  assign w_scan_wrap  = (r_scan_cnt == SCAN_LAST);
  assign w_frame_end  = w_scan_wrap && (r_idx == 3'd7);
  assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);
  assign w_nib        = nib_sel(r_snap.data, r_idx);
  assign w_blink_off  = r_phase && r_snap.blink[r_idx];

  seg7_decode u_decode (
    .i_nib   (w_nib),
    .o_seg   (w_seg7),
    .o_blank (w_blank)
  );

  // Segments are driven through the blanking window too; dig_sel alone keeps
  // the digit dark there, so the segment lines settle before the anode turns on.
  always_comb begin
    w_seg_nxt = SEG_OFF;
    if (disp.disp_en && !w_blink_off) begin
      w_seg_nxt = {w_blank | ~r_snap.dp[r_idx], w_seg7};
    end
  end

  always_comb begin
    w_dig_nxt = DIG_OFF;
    if (disp.disp_en && (r_scan_cnt >= BLANK_TH)) begin
      w_dig_nxt = ~(8'b0000_0001 << r_idx);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_idx       <= 3'd0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_snap      <= SNAP_RST;
      r_seg       <= SEG_OFF;
      r_dig_sel   <= DIG_OFF;
    end else begin
      if (w_scan_wrap) begin
        r_scan_cnt <= '0;
        r_idx      <= r_idx + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + SW'(1);
      end

      if (w_blink_wrap) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end

      // Inputs are frozen for a whole frame so a mid-scan update never tears.
      if (w_frame_end) begin
        r_snap <= '{data: disp.disp_data, blink: disp.blink_mask, dp: disp.dp_mask};
      end

      r_seg     <= w_seg_nxt;
      r_dig_sel <= w_dig_nxt;
    end
  end

  assign disp.seg     = r_seg;
  assign disp.dig_sel = r_dig_sel;

endmodule

// File: tb/tb_seg7_scan_disp.sv
// Bench for seg7_scan_disp: cycle-by-cycle reference model plus directed vector
// table and hand-written sequences for enable drop, mid-frame update and reset.
module tb_seg7_scan_disp;

  localparam int SCAN  = 8;
  localparam int BLANK = 2;
  localparam int BLINK = 64;
  localparam int FRAME = 8 * SCAN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_disp_if u_if ();

  seg7_scan_disp #(
    .SCAN_CNT  (SCAN),
    .BLANK_CYC (BLANK),
    .BLINK_CNT (BLINK)
  ) dut (
    .sys_clk (clk),
    .rst     (rst),
    .disp    (u_if.slave)
  );

  // ---------------- reference model ----------------
  // Display state is derived from the number of cycles since reset release.
  int          m_n;
  int          l_n;
  logic [31:0] m_data;
  logic [7:0]  m_blink;
  logic [7:0]  m_dp;
  logic [7:0]  seg_tab [16];

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q [$];

  function automatic logic [15:0] model_out(input int n, input logic en);
    int idx;
    int sc;
    int ph;
    logic [3:0] nib;
    logic [7:0] s;
    logic [7:0] d;
    idx = (n / SCAN) % 8;
    sc  = n % SCAN;
    ph  = (n / BLINK) % 2;
    nib = m_data[4*idx +: 4];
    s   = seg_tab[nib];
    if (nib <= 4'ha && m_dp[idx]) s[7] = 1'b0;
    if (!en || (ph == 1 && m_blink[idx])) s = 8'hFF;
    d = 8'hFF;
    if (en && sc >= BLANK) d = ~(8'b0000_0001 << idx);
    return {s, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [15:0] e;
    logic [15:0] a;
    if (rst) e = 16'hFFFF;
    else     e = model_out(m_n, u_if.disp_en);
    exp_q.push_back(e);
    if (rst) begin
      m_n     = 0;
      l_n     = -1;
      m_data  = 32'h00a00a00;
      m_blink = 8'h00;
      m_dp    = 8'h00;
    end else begin
      if (m_n % FRAME == FRAME - 1) begin
        m_data  = u_if.disp_data;
        m_blink = u_if.blink_mask;
        m_dp    = u_if.dp_mask;
      end
      l_n = m_n;
      m_n = m_n + 1;
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    a = {u_if.seg, u_if.dig_sel};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL model n=%0d seg/dig got %h/%h want %h/%h", l_n, a[15:8], a[7:0], e[15:8], e[7:0]);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic run_to(input int target);
    int b;
    b = 0;
    while (l_n != target && b < 3000) begin
      tick();
      b++;
    end
    if (l_n != target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_to got n=%0d want n=%0d", l_n, target);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] data;
    logic [7:0]  blink;
    logic [7:0]  dp;
    int          n;
    logic [7:0]  seg;
    logic [7:0]  dig;
  } vec_t;

  vec_t tab [$];

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    m_n = 0; l_n = -1;
    m_data = 32'h00a00a00; m_blink = 8'h00; m_dp = 8'h00;
    u_if.disp_data  = 32'h0;
    u_if.blink_mask = 8'h00;
    u_if.dp_mask    = 8'h00;
    u_if.disp_en    = 1'b1;

    // frame 1: plain 12-34-56 (phase 1, nothing blinking)
    tab.push_back('{32'h12a34a56, 8'h00, 8'h00, 64 + 0*8 + 4, 8'h82, 8'hFE});
    tab.push_back('{32'h12a34a56, 8'h00, 8'h00, 64 + 1*8 + 4, 8'h92, 8'hFD});
    tab.push_back('{32'h12a34a56, 8'h00, 8'h00, 64 + 2*8 + 4, 8'hBF, 8'hFB});
    tab.push_back('{32'h12a34a56, 8'h00, 8'h00, 64 + 3*8 + 4, 8'h99, 8'hF7});
    tab.push_back('{32'h12a34a56, 8'h00, 8'h00, 64 + 4*8 + 4, 8'hB0, 8'hEF});
    tab.push_back('{32'h12a34a56, 8'h00, 8'h00, 64 + 5*8 + 4, 8'hBF, 8'hDF});
    tab.push_back('{32'h12a34a56, 8'h00, 8'h00, 64 + 6*8 + 4, 8'hA4, 8'hBF});
    tab.push_back('{32'h12a34a56, 8'h00, 8'h00, 64 + 7*8 + 4, 8'hF9, 8'h7F});
    // frame 2: phase 0, blink C0 shows normally, dp on digit 4
    tab.push_back('{32'h12a34a56, 8'hC0, 8'h10, 128 + 4*8 + 4, 8'h30, 8'hEF});
    tab.push_back('{32'h12a34a56, 8'hC0, 8'h10, 128 + 6*8 + 4, 8'hA4, 8'hBF});
    tab.push_back('{32'h12a34a56, 8'hC0, 8'h10, 128 + 7*8 + 4, 8'hF9, 8'h7F});
    // frame 3: phase 1, digits 7/6 blanked while their anodes still scan
    tab.push_back('{32'h12a34a56, 8'hC0, 8'h10, 192 + 4*8 + 4, 8'h30, 8'hEF});
    tab.push_back('{32'h12a34a56, 8'hC0, 8'h10, 192 + 6*8 + 4, 8'hFF, 8'hBF});
    tab.push_back('{32'h12a34a56, 8'hC0, 8'h10, 192 + 7*8 + 4, 8'hFF, 8'h7F});

    // reset and first frame with data held at 0
    tick(); tick();
    chk("rst_seg", u_if.seg, 8'hFF);
    chk("rst_dig", u_if.dig_sel, 8'hFF);
    rst = 1'b0;
    tick();
    chk("first_dig_blank", u_if.dig_sel, 8'hFF);
    run_to(2);
    chk("slot0_seg", u_if.seg, 8'hC0);
    chk("slot0_dig", u_if.dig_sel, 8'hFE);
    run_to(5*8 + 4);
    chk("slot5_seg", u_if.seg, 8'hBF);
    chk("slot5_dig", u_if.dig_sel, 8'hDF);

    // table-driven vectors
    foreach (tab[i]) begin
      u_if.disp_data  = tab[i].data;
      u_if.blink_mask = tab[i].blink;
      u_if.dp_mask    = tab[i].dp;
      run_to(tab[i].n);
      chk($sformatf("vec%0d_seg", i), u_if.seg, tab[i].seg);
      chk($sformatf("vec%0d_dig", i), u_if.dig_sel, tab[i].dig);
    end

    // mid-frame update at idx 3 must not tear frame 4
    run_to(256 + 3*8);
    u_if.disp_data  = 32'h98a76a54;
    u_if.blink_mask = 8'h00;
    u_if.dp_mask    = 8'h00;
    run_to(256 + 4*8 + 4);
    chk("midframe_old_d4", u_if.seg, 8'h30);
    run_to(256 + 7*8 + 4);
    chk("midframe_old_d7", u_if.seg, 8'hF9);
    run_to(320 + 0*8 + 4);
    chk("newframe_d0_seg", u_if.seg, 8'h99);
    chk("newframe_d0_dig", u_if.dig_sel, 8'hFE);
    run_to(320 + 7*8 + 4);
    chk("newframe_d7_seg", u_if.seg, 8'h90);
    u_if.disp_data = 32'h12a34a56;

    // disp_en dropped for 20 cycles mid-slot
    run_to(384 + 2*8 + 3);
    u_if.disp_en = 1'b0;
    tick();
    chk("en_off_seg", u_if.seg, 8'hFF);
    chk("en_off_dig", u_if.dig_sel, 8'hFF);
    for (int i = 0; i < 19; i++) tick();
    u_if.disp_en = 1'b1;
    tick();
    chk("en_on_blank_seg", u_if.seg, 8'hBF);
    chk("en_on_blank_dig", u_if.dig_sel, 8'hFF);
    tick(); tick();
    chk("en_on_dig", u_if.dig_sel, 8'hDF);

    // one-cycle reset at idx 5 of a frame showing 12-34-56
    run_to(448 + 5*8 + 3);
    chk("pre_rst_seg", u_if.seg, 8'hBF);
    rst = 1'b1;
    tick();
    chk("midrst_seg", u_if.seg, 8'hFF);
    chk("midrst_dig", u_if.dig_sel, 8'hFF);
    rst = 1'b0;
    tick();
    chk("postrst_seg", u_if.seg, 8'hC0);
    chk("postrst_dig", u_if.dig_sel, 8'hFF);
    run_to(5*8 + 4);
    chk("postrst_d5_seg", u_if.seg, 8'hBF);
    run_to(7*8 + 4);
    chk("postrst_d7_seg", u_if.seg, 8'hC0);
    chk("postrst_d7_dig", u_if.dig_sel, 8'h7F);
    run_to(64 + 7*8 + 4);
    chk("postrst_next_d7", u_if.seg, 8'hF9);

    // randomized stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) u_if.disp_data = $urandom;
      if ($urandom_range(0, 15) == 0) u_if.blink_mask = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) u_if.dp_mask = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 39) == 0) u_if.disp_en = ~u_if.disp_en;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
